bus_burst_slave_mem: RTL and testbench
======================================

# bus_burst_slave_mem

Burst-capable bus target memory that sits on the same bus as the DMA custom instruction and serves its read and write bursts. It decodes `beginTransactionIn` address/size/direction and streams words back with `dataValidOut` or absorbs written words with byte enables. It ends read bursts with `endTransactionOut` and flags bad accesses with `busErrorOut`. It is the far-side partner that gives the DMA's bus master port real sequential behaviour in simulation and on FPGA.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0.
- `DEPTH_LOG2`, 10, memory depth in 32-bit words (2^DEPTH_LOG2).
- `READ_LATENCY`, 2, cycles from the begin cycle to the first read data (1..15).

- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `beginTransactionIn` in 1: one-cycle transaction start.
- `addressDataIn` in 32: start byte address on the begin cycle; write data otherwise.
- `burstSizeIn` in 8: words minus 1, sampled on the begin cycle.
- `readNotWriteIn` in 1: 1 = read, sampled on the begin cycle.
- `byteEnablesIn` in 4: per-byte write enables, valid with `dataValidIn`.
- `dataValidIn` in 1: write word present.
- `endTransactionIn` in 1: master ends a write burst.
- `addressDataOut` out 32: read data; 0 when not `dataValidOut`.
- `dataValidOut` out 1: read word valid.
- `endTransactionOut` out 1: one-cycle end of a read burst.
- `busErrorOut` out 1: one-cycle error pulse.
- `busyOut` out 1: write stall, master must hold the word.

## Operation
- States: IDLE, READ_WAIT, READ_BURST, READ_END, WRITE_BURST, ERROR.
- **IDLE**
  - `beginTransactionIn` latches the address, count N = `burstSizeIn`+1 and direction.
  - Range check, all three must pass:
    - `addressDataIn[1:0]`==0.
    - Start ≥ `BASE_ADDR`.
    - Start + 4·(N−1) < `BASE_ADDR` + 4·2^DEPTH_LOG2.
  - Check fails -> ERROR. Otherwise -> READ_WAIT or WRITE_BURST.
- **READ_WAIT**
  - Counts READ_LATENCY−1 cycles while prefetching word 0 from the synchronous RAM.
  - Then -> READ_BURST.
- **READ_BURST**
  - Exactly N consecutive cycles with `dataValidOut`=1.
  - Word index increments by 1 per cycle and never wraps (guaranteed by the range check).
  - -> READ_END.
- **READ_END**
  - `endTransactionOut`=1 for one cycle, then -> IDLE.
- **WRITE_BURST**
  - A word is committed when `dataValidIn`=1 and `busyOut`=0.
  - Only lanes with `byteEnablesIn` set are written; the word index increments per commit.
  - Words beyond N are ignored.
  - `endTransactionIn` -> IDLE at any point. An early end simply stops the burst; written words stay.
- **ERROR**
  - `busErrorOut`=1 for one cycle, no data, no `endTransactionOut`, then -> IDLE.
- `beginTransactionIn` outside IDLE is ignored.
- `burstSizeIn`=0 is a single-word burst. `burstSizeIn`=255 is 256 words.
- Memory contents are not cleared by reset.

## Timing
- Reset (`reset`=0) forces, immediately and asynchronously:
  - State = IDLE.
  - All outputs 0: `addressDataOut`, `dataValidOut`, `endTransactionOut`, `busErrorOut`, `busyOut`.
- Reset mid-burst abandons the burst. A write already committed stays in memory.
- Read timing, with the begin sampled at edge T:
  - First `dataValidOut` during cycle T+READ_LATENCY.
  - Last word at T+READ_LATENCY+N−1.
  - `endTransactionOut` at T+READ_LATENCY+N.
  - IDLE at T+READ_LATENCY+N+1.
- A new begin is accepted the cycle after returning to IDLE.
- Write timing:
  - First word accepted at the earliest in cycle T+1.
  - Back-to-back words, one per cycle, when not stalled.
- Error timing: `busErrorOut` during cycle T+1, IDLE at T+2.
- `busyOut` is a registered output and changes only on clock edges.

## Configuration
- `BUS_SLAVE_BUSY_INJECT_EN` defined:
  - In WRITE_BURST, after every 3rd committed word `busyOut`=1 for exactly 1 cycle.
  - `dataValidIn` in that cycle is not committed; the master holds the word.
- Not defined: `busyOut` is constant 0 and every valid word commits in its cycle.

## Test plan
- Write-then-read burst:
  - Write burst at 0x0000_0037: ERROR, `busErrorOut` pulse at T+1, memory unchanged.
  - Write burst at 0x0000_0034, `burstSizeIn`=2, data 10,20,30: read back -> `dataValidOut` at T+2..T+4 with 10,20,30, `endTransactionOut` at T+5.
- Byte enables:
  - Write 0xAABBCCDD with `byteEnablesIn`=4'b0101 over a word holding 0: reads back as 0x00BB00DD.
- Range boundary (`DEPTH_LOG2`=10):
  - Begin read at 0xFF8 with `burstSizeIn`=1: 2 words returned.
  - Same begin with `burstSizeIn`=2: `busErrorOut`, no `dataValidOut`.
- Early write end and reset:
  - `endTransactionIn` after 1 of 3 words: word 1 written, words 2–3 unchanged.
  - `reset` low during READ_BURST: all outputs 0 at once; after release, a new read works.
- Stall injection (`BUS_SLAVE_BUSY_INJECT_EN`):
  - 6-word write: `busyOut` pulses after words 3 and 6.
  - Held data is committed once; readback matches the 6 words.
- Ignored begin:
  - `beginTransactionIn` asserted during READ_BURST: no effect, burst length unchanged.

Source files
------------

// File: rtl/bus_burst_slave_mem_if.sv
// Bus between the DMA master and the burst target memory.
// Handshake: a begin pulse opens a burst; a write word moves on a cycle with
// dataValidIn=1 and busyOut=0; read words move on every dataValidOut=1 cycle.
interface bus_burst_slave_mem_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  modport slave (
    input  beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
           byteEnablesIn, dataValidIn, endTransactionIn,
    output addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
  );

  modport master (
    output beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
           byteEnablesIn, dataValidIn, endTransactionIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
  );
endinterface

// File: rtl/bus_burst_slave_mem.sv
// Burst target memory serving sequential read/write bursts from the DMA master.
// Optional BUS_SLAVE_BUSY_INJECT_EN: one busy cycle after every 3rd committed write word.
module bus_burst_slave_mem #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DEPTH_LOG2   = 10,
  parameter int          READ_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_burst_slave_mem_if.slave bus,
  output logic [2:0]           state_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
  localparam logic [33:0] BASE_W  = {2'b00, BASE_ADDR};
  localparam logic [33:0] LIMIT_W = BASE_W + (34'd4 << DEPTH_LOG2);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ_WAIT   = 3'd1;
  localparam logic [2:0] S_READ_BURST  = 3'd2;
  localparam logic [2:0] S_READ_END    = 3'd3;
  localparam logic [2:0] S_WRITE_BURST = 3'd4;
  localparam logic [2:0] S_ERROR       = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [3:0]            wait_q, wait_d;
  logic                  busy_q, busy_d;
  logic                  wr_en;
  logic                  range_ok;
  logic [33:0]           start_w, last_w;
  logic [DEPTH_LOG2-1:0] start_idx, rd_idx;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rdata_q;

  always_comb begin
    start_w   = {2'b00, bus.addressDataIn};
    last_w    = start_w + {24'd0, bus.burstSizeIn, 2'b00};
    range_ok  = (bus.addressDataIn[1:0] == 2'b00) && (start_w >= BASE_W) && (last_w < LIMIT_W);
    start_idx = DEPTH_LOG2'((bus.addressDataIn - BASE_ADDR) >> 2);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.beginTransactionIn) begin
          idx_d = start_idx;
          if (!range_ok) begin
            state_d = S_ERROR;
          end else if (bus.readNotWriteIn) begin
            // Reads count down from N-1 so the last word is the cnt==0 cycle.
            cnt_d   = {1'b0, bus.burstSizeIn};
            wait_d  = WAIT_INIT;
            state_d = (READ_LATENCY > 1) ? S_READ_WAIT : S_READ_BURST;
          end else begin
            cnt_d   = {1'b0, bus.burstSizeIn} + 9'd1;
            state_d = S_WRITE_BURST;
          end
        end
      end
      S_READ_WAIT: begin
        if (wait_q == 4'd0) state_d = S_READ_BURST;
        else                wait_d  = wait_q - 4'd1;
      end
      S_READ_BURST: begin
        if (cnt_q == 9'd0) begin
          state_d = S_READ_END;
        end else begin
          cnt_d = cnt_q - 9'd1;
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_READ_END: state_d = S_IDLE;
      S_ERROR:    state_d = S_IDLE;
      S_WRITE_BURST: begin
        // Writes count remaining words; surplus words after N are dropped.
        if (bus.dataValidIn && !busy_q && (cnt_q != 9'd0)) begin
          wr_en = 1'b1;
          cnt_d = cnt_q - 9'd1;
          idx_d = idx_q + IDX_ONE;
        end
        if (bus.endTransactionIn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BUS_SLAVE_BUSY_INJECT_EN
  logic [1:0] third_q, third_d;

  always_comb begin
    third_d = third_q;
    busy_d  = 1'b0;
    if (state_q != S_WRITE_BURST) begin
      third_d = 2'd0;
    end else if (wr_en) begin
      if (third_q == 2'd2) begin
        third_d = 2'd0;
        busy_d  = !bus.endTransactionIn;
      end else begin
        third_d = third_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) third_q <= 2'd0;
    else        third_q <= third_d;
  end
`else
  assign busy_d = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= 9'd0;
      wait_q  <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
    end
  end

  // Read port runs one word ahead of the word currently on the bus.
  always_comb begin
    case (state_q)
      S_IDLE:      rd_idx = start_idx;
      S_READ_WAIT: rd_idx = idx_q;
      default:     rd_idx = idx_q + IDX_ONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteEnablesIn[b]) mem_q[idx_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
      end
    end
    rdata_q <= mem_q[rd_idx];
  end

  assign bus.dataValidOut      = (state_q == S_READ_BURST);
  assign bus.addressDataOut    = bus.dataValidOut ? rdata_q : 32'd0;
  assign bus.endTransactionOut = (state_q == S_READ_END);
  assign bus.busErrorOut       = (state_q == S_ERROR);
  assign bus.busyOut           = busy_q;
  assign state_o               = state_q;
endmodule

// File: tb/tb_bus_burst_slave_mem.sv
// Self-checking bench for bus_burst_slave_mem: directed bursts, boundaries,
// early end, mid-burst reset and an ignored begin, with a read-data scoreboard.
module tb_bus_burst_slave_mem;
  localparam int          RL    = 2;
  localparam int          DL    = 10;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 1 << DL;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] state;

  always #5 clock = ~clock;

  bus_burst_slave_mem_if bus();

  bus_burst_slave_mem #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL), .READ_LATENCY(RL)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [WORDS];
  logic [31:0] wd  [256];
  logic [3:0]  wbe [256];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a, input int n);
    longint last;
    last = longint'(a) + 4 * (n - 1);
    return (a[1:0] == 2'b00) && (a >= BASE) && (last < longint'(BASE) + 4 * WORDS);
  endfunction

  // Scoreboard: every valid read word must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset && bus.dataValidOut) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rd_data", bus.addressDataOut, exp_q.pop_front());
    end
  end

  task automatic start(input logic [31:0] addr, input int bsize, input logic rnw);
    @(posedge clock); #1;
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = addr;
    bus.burstSizeIn        = 8'(bsize);
    bus.readNotWriteIn     = rnw;
    @(posedge clock); #1;
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int bsize, input int n_send,
                          output int busy_n, output int busy_at0, output int busy_at1);
    int i;
    int guard;
    int idx;
    logic b;
    busy_n = 0; busy_at0 = -1; busy_at1 = -1;
    i = 0; guard = 0;
    start(addr, bsize, 1'b0);
    while (i < n_send && guard < 200) begin
      bus.dataValidIn   = 1'b1;
      bus.addressDataIn = wd[i];
      bus.byteEnablesIn = wbe[i];
      @(negedge clock);
      b = bus.busyOut;
      if (b) begin
        if (busy_n == 0) busy_at0 = i; else busy_at1 = i;
        busy_n++;
      end
      @(posedge clock); #1;
      if (!b) begin
        if (i <= bsize) begin
          idx = int'((addr - BASE) >> 2) + i;
          for (int k = 0; k < 4; k++)
            if (wbe[i][k]) model[idx][8*k +: 8] = wd[i][8*k +: 8];
        end
        i++;
      end
      guard++;
    end
    check("wr_sent", 32'(i), 32'(n_send));
    bus.dataValidIn      = 1'b0;
    bus.byteEnablesIn    = 4'd0;
    bus.addressDataIn    = 32'd0;
    bus.endTransactionIn = 1'b1;
    @(negedge clock);
    if (bus.busyOut) begin
      if (busy_n == 0) busy_at0 = i; else busy_at1 = i;
      busy_n++;
    end
    @(posedge clock); #1;
    bus.endTransactionIn = 1'b0;
    check("wr_idle", 32'(state), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int bsize, input bit inject);
    int n, first, cnt, endk, errk, nz, ends, st_after;
    bit ok;
    n = bsize + 1;
    ok = addr_ok(addr, n);
    if (ok) for (int i = 0; i < n; i++) exp_q.push_back(model[int'((addr - BASE) >> 2) + i]);
    first = 0; cnt = 0; endk = 0; errk = 0; nz = 0; ends = 0; st_after = -1;
    start(addr, bsize, 1'b1);
    for (int k = 1; k <= RL + n + 3; k++) begin
      @(negedge clock);
      if (bus.dataValidOut) begin
        cnt++;
        if (first == 0) first = k;
      end else if (bus.addressDataOut != 32'd0) begin
        nz++;
      end
      if (bus.endTransactionOut) begin endk = k; ends++; end
      if (bus.busErrorOut) errk = k;
      if (k == (ok ? RL + n + 1 : 2)) st_after = int'(state);
      if (inject && k == RL + 1) begin
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = 32'h0000_0100;
        bus.burstSizeIn        = 8'd7;
        bus.readNotWriteIn     = 1'b1;
        @(posedge clock); #1;
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'd0;
      end
    end
    check("rd_idle_after", 32'(st_after), 32'd0);
    check("rd_idle_zero", 32'(nz), 32'd0);
    if (ok) begin
      check("rd_first", 32'(first), 32'(RL));
      check("rd_count", 32'(cnt), 32'(n));
      check("rd_end", 32'(endk), 32'(RL + n));
      check("rd_end_once", 32'(ends), 32'd1);
      check("rd_noerr", 32'(errk), 32'd0);
    end else begin
      check("rd_err_at", 32'(errk), 32'd1);
      check("rd_err_nodata", 32'(cnt), 32'd0);
      check("rd_err_noend", 32'(endk), 32'd0);
    end
  endtask

  task automatic err_write(input logic [31:0] addr, input int bsize);
    logic e1, e2, d;
    start(addr, bsize, 1'b0);
    @(negedge clock); e1 = bus.busErrorOut; d = bus.dataValidOut;
    @(negedge clock); e2 = bus.busErrorOut;
    check("werr_pulse", 32'(e1), 32'd1);
    check("werr_one_cycle", 32'(e2), 32'd0);
    check("werr_nodata", 32'(d), 32'd0);
    check("werr_idle", 32'(state), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dv"},   32'(bus.dataValidOut), 32'd0);
    check({tag, "_data"}, bus.addressDataOut, 32'd0);
    check({tag, "_end"},  32'(bus.endTransactionOut), 32'd0);
    check({tag, "_err"},  32'(bus.busErrorOut), 32'd0);
    check({tag, "_busy"}, 32'(bus.busyOut), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    int bn, b0, b1, guard;
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = 32'd0;
    bus.burstSizeIn        = 8'd0;
    bus.readNotWriteIn     = 1'b0;
    bus.byteEnablesIn      = 4'd0;
    bus.dataValidIn        = 1'b0;
    bus.endTransactionIn   = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'd0;

    repeat (3) @(posedge clock);
    #1 check_quiet("rst_hold");
    @(negedge clock) reset = 1'b1;
    @(negedge clock) check_quiet("rst_rel");

    // Seed a region, then an unaligned write must error and leave it intact.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wbe[i] = 4'hF; end
    do_write(32'h30, 3, 4, bn, b0, b1);
    err_write(32'h37, 0);
    do_read(32'h30, 3, 1'b0);

    wd[0] = 32'd10; wd[1] = 32'd20; wd[2] = 32'd30;
    for (int i = 0; i < 3; i++) wbe[i] = 4'hF;
    do_write(32'h34, 2, 3, bn, b0, b1);
    do_read(32'h34, 2, 1'b0);

    wd[0] = 32'd0; wbe[0] = 4'hF;
    do_write(32'h100, 0, 1, bn, b0, b1);
    wd[0] = 32'hAABB_CCDD; wbe[0] = 4'b0101;
    do_write(32'h100, 0, 1, bn, b0, b1);
    check("be_model", model[32'h100 >> 2], 32'h00BB_00DD);
    do_read(32'h100, 0, 1'b0);

    // Top-of-memory boundary.
    wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002; wbe[0] = 4'hF; wbe[1] = 4'hF;
    do_write(32'hFF8, 1, 2, bn, b0, b1);
    do_read(32'hFF8, 1, 1'b0);
    do_read(32'hFF8, 2, 1'b0);
    do_read(32'hFFC, 0, 1'b0);
    do_read(32'h1000, 0, 1'b0);

    // Early end after one word of three.
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
    for (int i = 0; i < 3; i++) wbe[i] = 4'hF;
    do_write(32'h200, 2, 3, bn, b0, b1);
    wd[0] = 32'hA1;
    do_write(32'h200, 2, 1, bn, b0, b1);
    do_read(32'h200, 2, 1'b0);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 4; i++) exp_q.push_back(model[(32'h30 >> 2) + i]);
    start(32'h30, 3, 1'b1);
    guard = 0;
    while (!bus.dataValidOut && guard < 20) begin @(negedge clock); guard++; end
    check("rstb_dv_seen", 32'(bus.dataValidOut), 32'd1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1 check_quiet("rst_mid");
    exp_q.delete();
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    do_read(32'h34, 2, 1'b0);

    // A begin during READ_BURST must not disturb the burst.
    do_read(32'h30, 3, 1'b1);

    // Stall behaviour on a 6-word write.
    for (int i = 0; i < 6; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
    do_write(32'h400, 5, 6, bn, b0, b1);
`ifdef BUS_SLAVE_BUSY_INJECT_EN
    check("busy_pulses", 32'(bn), 32'd2);
    check("busy_after_a", 32'(b0), 32'd3);
    check("busy_after_b", 32'(b1), 32'd6);
`else
    check("busy_never", 32'(bn), 32'd0);
`endif
    do_read(32'h400, 5, 1'b0);

    // Random data with random byte lanes over a fully-written block.
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
    do_write(32'h300, 7, 8, bn, b0, b1);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wbe[i] = 4'($urandom_range(0, 15)); end
    do_write(32'h300, 7, 8, bn, b0, b1);
    do_read(32'h300, 7, 1'b0);

    repeat (2) @(negedge clock);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
